rename_register_file: RTL

//  Architectural register file plus rename table; the responder to the reorder buffer's launch, commit and query traffic.

---
 rtl/rename_register_file_pkg.sv | 29 ++
 rtl/rename_register_file_query_port.sv | 31 +++
 rtl/rename_register_file.sv | 82 ++++++++
 3 files changed

// File: rtl/rename_register_file_pkg.sv
// Shared widths, the "no dependency" tag and the rd-writing opcode list
// used by both the register file and the reorder buffer.
package rename_register_file_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_REGS     = 32;
  localparam int ROB_ID_WIDTH = 5;
  localparam int REG_ID_WIDTH = $clog2(NUM_REGS);

  localparam logic [ROB_ID_WIDTH-1:0] NO_DEP = '0;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LOAD   = 7'b0000011,
    OP_OP_IMM = 7'b0010011,
    OP_OP     = 7'b0110011
  } rd_write_op_e;

  function automatic logic op_writes_rd(input logic [6:0] opcode);
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OP_IMM, OP_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rename_register_file_query_port.sv
// One decoder source lookup: index mux over the rename/value tables with a
// same-cycle commit bypass. Launches are deliberately not bypassed.
module rf_query_port
  import rename_register_file_pkg::*;
(
  input  logic [REG_ID_WIDTH-1:0]                 ask,
  input  logic [NUM_REGS-1:1][ROB_ID_WIDTH-1:0]   dep_tbl,
  input  logic [NUM_REGS-1:1][XLEN-1:0]           value_tbl,
  input  logic                                    commit_ready,
  input  logic [ROB_ID_WIDTH-1:0]                 commit_rob_id,
  input  logic [REG_ID_WIDTH-1:0]                 commit_register_id,
  input  logic [XLEN-1:0]                         commit_value,
  output logic [ROB_ID_WIDTH-1:0]                 dep,
  output logic [XLEN-1:0]                         value
);

  always_comb begin
    dep   = NO_DEP;
    value = '0;
    if (ask != '0) begin
      dep   = dep_tbl[ask];
      value = value_tbl[ask];
      // Only the producer the table is waiting on may resolve the source early.
      if (commit_ready && (commit_register_id == ask) && (dep_tbl[ask] == commit_rob_id)) begin
        dep   = NO_DEP;
        value = commit_value;
      end
    end
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file plus rename table, driven by ROB launch,
// commit and clear traffic; two combinational query ports for the decoder.
module rename_register_file
  import rename_register_file_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    _clear,
  input  logic                    _rf_launch_ready,
  input  logic [ROB_ID_WIDTH-1:0] _rf_launch_rob_id,
  input  logic [REG_ID_WIDTH-1:0] _rf_launch_register_id,
  input  logic                    _rf_commit_ready,
  input  logic [ROB_ID_WIDTH-1:0] _rf_commit_rob_id,
  input  logic [REG_ID_WIDTH-1:0] _rf_commit_register_id,
  input  logic [XLEN-1:0]         _rf_commit_value,
  input  logic [REG_ID_WIDTH-1:0] _ask_rd_1,
  input  logic [REG_ID_WIDTH-1:0] _ask_rd_2,
  output logic [ROB_ID_WIDTH-1:0] _dep_rd_1,
  output logic [XLEN-1:0]         _dep_value_1,
  output logic [ROB_ID_WIDTH-1:0] _dep_rd_2,
  output logic [XLEN-1:0]         _dep_value_2
);

  logic [NUM_REGS-1:1][XLEN-1:0]         value_q, value_d;
  logic [NUM_REGS-1:1][ROB_ID_WIDTH-1:0] dep_q, dep_d;
  logic                                  commit_en, launch_en, clear_en;

  assign commit_en = rdy_in && _rf_commit_ready && (_rf_commit_register_id != '0);
  assign clear_en  = rdy_in && _clear;
  assign launch_en = rdy_in && _rf_launch_ready && (_rf_launch_register_id != '0) && !_clear;

  always_comb begin
    value_d = value_q;
    dep_d   = dep_q;
    if (commit_en) begin
      value_d[_rf_commit_register_id] = _rf_commit_value;
      // A younger launch to the same rd keeps its tag.
      if (dep_q[_rf_commit_register_id] == _rf_commit_rob_id)
        dep_d[_rf_commit_register_id] = NO_DEP;
    end
    if (clear_en)
      dep_d = '0;
    else if (launch_en)
      dep_d[_rf_launch_register_id] = _rf_launch_rob_id;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_q <= '0;
      dep_q   <= '0;
    end else begin
      value_q <= value_d;
      dep_q   <= dep_d;
    end
  end

  rf_query_port u_query_1 (
    .ask                (_ask_rd_1),
    .dep_tbl            (dep_q),
    .value_tbl          (value_q),
    .commit_ready       (_rf_commit_ready),
    .commit_rob_id      (_rf_commit_rob_id),
    .commit_register_id (_rf_commit_register_id),
    .commit_value       (_rf_commit_value),
    .dep                (_dep_rd_1),
    .value              (_dep_value_1)
  );

  rf_query_port u_query_2 (
    .ask                (_ask_rd_2),
    .dep_tbl            (dep_q),
    .value_tbl          (value_q),
    .commit_ready       (_rf_commit_ready),
    .commit_rob_id      (_rf_commit_rob_id),
    .commit_register_id (_rf_commit_register_id),
    .commit_value       (_rf_commit_value),
    .dep                (_dep_rd_2),
    .value              (_dep_value_2)
  );

endmodule
